// File: rtl/result_unloader_pkg.sv
// rtl/result_unloader_pkg.sv - state encoding and chunk-count helpers shared by the unloader, its bench and the port-A arbiter
package result_unloader_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ADDR  = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam logic [1:0] SHIFT = 2'd3;

    // Number of OUT_W chunks needed to carry one DATA_W word
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Counter width able to index 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/result_unloader.sv
// rtl/result_unloader.sv - streams result RAM words out as LSB-first chunks; RESULT_UNLOADER_PARITY_EN adds out_parity
module result_unloader
    import result_unloader_pkg::*;
#(
    parameter int         DATA_W    = 198,
    parameter int         OUT_W     = 32,
    parameter int         NUM_WORDS = 6,
    parameter logic [5:0] BASE_ADDR = 6'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done,
    output logic [5:0]        ram_a_addr,
    output logic              ram_a_req,
    input  logic [DATA_W-1:0] ram_a_q,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
`ifdef RESULT_UNLOADER_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    localparam int CHUNKS = ceil_div(DATA_W, OUT_W);
    localparam int CW     = cnt_width(CHUNKS);
    localparam int WW     = cnt_width(NUM_WORDS);

    localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);
    localparam logic [WW-1:0] LAST_WORD  = WW'(NUM_WORDS - 1);

    logic [1:0]        state;
    logic [CW-1:0]     chunk_idx;
    logic [WW-1:0]     word_idx;
    logic [DATA_W-1:0] shift_reg;

    logic              xfer;
    logic              final_chunk;
    logic              final_word;
    logic              data_en;
    logic [OUT_W-1:0]  next_data;

    // Handshake and position decode; out_valid is a register so it never follows out_ready
    always_comb begin
        xfer        = out_valid && out_ready;
        final_chunk = (chunk_idx == LAST_CHUNK);
        final_word  = (word_idx == LAST_WORD);
        data_en     = (state == LOAD) || ((state == SHIFT) && xfer && !final_chunk);
        // Size casts truncate wide words and zero-extend a short final chunk
        next_data   = (state == LOAD) ? OUT_W'(ram_a_q) : OUT_W'(shift_reg);
    end

    // Port-A ownership is a pure function of state so the external mux can key on ram_a_req
    always_comb begin
        ram_a_req  = (state == ADDR) || (state == LOAD);
        ram_a_addr = (state == ADDR) ? (BASE_ADDR + 6'(word_idx)) : 6'd0;
        busy       = (state != IDLE);
    end

    // Sequencer: fetch a word, wait one cycle for RAM data, then drain it chunk by chunk
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (done) state <= ADDR;
                ADDR:    state <= LOAD;
                LOAD:    state <= SHIFT;
                SHIFT: begin
                    if (xfer && final_chunk) begin
                        state <= final_word ? IDLE : ADDR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Chunk and word position; both saturate at their final value instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            chunk_idx <= '0;
            word_idx  <= '0;
        end else if ((state == IDLE) && done) begin
            chunk_idx <= '0;
            word_idx  <= '0;
        end else if (state == LOAD) begin
            chunk_idx <= '0;
        end else if ((state == SHIFT) && xfer) begin
            if (!final_chunk) begin
                chunk_idx <= chunk_idx + CW'(1);
            end else if (!final_word) begin
                word_idx <= word_idx + WW'(1);
            end
        end
    end

    // Output register and shift register; chunk 0 goes straight from RAM data, the remainder is parked
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (state == LOAD) begin
            shift_reg <= ram_a_q >> OUT_W;
            out_data  <= next_data;
            out_valid <= 1'b1;
            out_last  <= final_word && (CHUNKS == 1);
        end else if ((state == SHIFT) && xfer) begin
            if (!final_chunk) begin
                shift_reg <= shift_reg >> OUT_W;
                out_data  <= next_data;
                out_last  <= final_word && ((chunk_idx + CW'(1)) == LAST_CHUNK);
            end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef RESULT_UNLOADER_PARITY_EN
    // Parity tracks out_data exactly: same load enable, so it holds through stalls too
    always_ff @(posedge clk) begin
        if (reset) begin
            out_parity <= 1'b0;
        end else if (data_en) begin
            out_parity <= ^next_data;
        end
    end
`endif

endmodule

// File: tb/tb_result_unloader.sv
// tb/tb_result_unloader.sv - directed self-checking bench for result_unloader
module tb_result_unloader;

    logic         clk = 1'b0;
    logic         reset;
    logic         done;
    logic [5:0]   ram_a_addr;
    logic         ram_a_req;
    logic [197:0] ram_a_q;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
`ifdef RESULT_UNLOADER_PARITY_EN
    logic         out_parity;
`endif

    logic [197:0] mem [64];
    logic [31:0]  got [64];
    logic         gl  [64];
    logic         gp  [64];

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    result_unloader dut (
        .clk        (clk),
        .reset      (reset),
        .done       (done),
        .ram_a_addr (ram_a_addr),
        .ram_a_req  (ram_a_req),
        .ram_a_q    (ram_a_q),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
`ifdef RESULT_UNLOADER_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM, one cycle of latency
    always @(posedge clk) ram_a_q <= mem[ram_a_addr];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_k1();
        for (int k = 0; k < 64; k++) mem[k] = '0;
        for (int k = 0; k < 6; k++) mem[k] = 198'(k + 1);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    // Drain the stream; mode 1 drives out_ready as 1,0,0,1 repeating and checks stall stability
    task automatic stream(input int mode, input int done_at, input int abort_at, output int cnt);
        int          i;
        logic        stall;
        logic [31:0] hd;
        logic        hl;
        logic        hp;
        cnt   = 0;
        stall = 1'b0;
        hd    = '0;
        hl    = 1'b0;
        hp    = 1'b0;
        i     = 0;
        while (i < 2000) begin
            if (stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, hd);
                chk("stall_last", out_last, hl);
`ifdef RESULT_UNLOADER_PARITY_EN
                chk("stall_parity", out_parity, hp);
`endif
            end
            if (!busy) break;
            out_ready = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
            done      = (i == done_at);
            if (out_valid && out_ready) begin
                if (cnt < 64) begin
                    got[cnt] = out_data;
                    gl[cnt]  = out_last;
`ifdef RESULT_UNLOADER_PARITY_EN
                    gp[cnt]  = out_parity;
`endif
                end
                cnt++;
            end
            stall = out_valid && !out_ready;
            hd    = out_data;
            hl    = out_last;
`ifdef RESULT_UNLOADER_PARITY_EN
            hp    = out_parity;
`endif
            if ((abort_at > 0) && (cnt == abort_at)) break;
            @(negedge clk);
            i++;
        end
        done = 1'b0;
        chk("stream_timeout", (i < 2000), 1'b1);
    endtask

    // Words hold k+1: chunk 0 of word k is k+1, other chunks zero, last flag only on chunk 41
    task automatic check_k1(input string tag, input int cnt);
        chk({tag, "_count"}, cnt, 42);
        for (int j = 0; j < 42 && j < cnt; j++) begin
            chk($sformatf("%s_data%0d", tag, j), got[j], (j % 7 == 0) ? (j / 7 + 1) : 0);
            chk($sformatf("%s_last%0d", tag, j), gl[j], (j == 41));
        end
    endtask

    initial begin
        reset     = 1'b1;
        done      = 1'b0;
        out_ready = 1'b0;
        load_k1();
        for (int k = 0; k < 64; k++) gp[k] = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req", ram_a_req, 1'b0);
        chk("rst_addr", ram_a_addr, 6'd0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_last", out_last, 1'b0);
        reset = 1'b0;

        // Basic unload, ready held high, with latency checks
        @(negedge clk);
        done      = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("a_addr_busy", busy, 1'b1);
        chk("a_addr_req", ram_a_req, 1'b1);
        chk("a_addr_addr", ram_a_addr, 6'd0);
        chk("a_addr_valid", out_valid, 1'b0);
        @(negedge clk);
        chk("a_load_req", ram_a_req, 1'b1);
        chk("a_load_addr", ram_a_addr, 6'd0);
        chk("a_load_valid", out_valid, 1'b0);
        @(negedge clk);
        chk("a_first_valid", out_valid, 1'b1);
        chk("a_first_req", ram_a_req, 1'b0);
        chk("a_first_data", out_data, 32'h1);
        stream(0, -1, 0, n);
        check_k1("a", n);
        @(negedge clk);
        chk("a_end_busy", busy, 1'b0);
        chk("a_end_valid", out_valid, 1'b0);

        // Backpressure 1,0,0,1
        pulse_done();
        stream(1, -1, 0, n);
        check_k1("b", n);

        // All-ones word exercises the zero-extended final chunk
        mem[0] = {198{1'b1}};
        pulse_done();
        stream(0, -1, 0, n);
        chk("c_count", n, 42);
        for (int j = 0; j < 6; j++) chk($sformatf("c_ones%0d", j), got[j], 32'hFFFF_FFFF);
        chk("c_tail", got[6], 32'h0000_003F);
        chk("c_word1", got[7], 32'h2);
        chk("c_last41", gl[41], 1'b1);
        chk("c_last6", gl[6], 1'b0);
        mem[0] = 198'd1;

        // Second done while busy is dropped
        pulse_done();
        stream(0, 9, 0, n);
        check_k1("d", n);
        repeat (3) @(negedge clk);
        chk("d_not_queued", busy, 1'b0);

        // Reset mid-transfer, then a clean restart
        pulse_done();
        stream(0, -1, 21, n);
        chk("e_partial", n, 21);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("e_rst_valid", out_valid, 1'b0);
        chk("e_rst_busy", busy, 1'b0);
        chk("e_rst_last", out_last, 1'b0);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("e_restart_addr", ram_a_addr, 6'd0);
        stream(0, -1, 0, n);
        check_k1("e", n);

`ifdef RESULT_UNLOADER_PARITY_EN
        mem[0] = 198'h3_0000_0007;
        pulse_done();
        stream(1, -1, 0, n);
        chk("p_data0", got[0], 32'h7);
        chk("p_par0", gp[0], 1'b1);
        chk("p_data1", got[1], 32'h3);
        chk("p_par1", gp[1], 1'b0);
        chk("p_par7", gp[7], 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/result_unloader.md
RESULT_UNLOADER -- requirements
Module: result_unloader

Interface
REQ-001 SHALL have parameter DATA_W, default 198, meaning the width of one RAM word.
REQ-002 SHALL have parameter OUT_W, default 32, meaning the width of one output chunk.
REQ-003 SHALL have parameter NUM_WORDS, default 6, meaning the number of RAM words in the final result.
REQ-004 SHALL have parameter BASE_ADDR, default 6'd0, meaning the RAM address of the first result word.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port done, input, 1 bit: one-cycle completion pulse from the command sequencer.
REQ-008 SHALL have port ram_a_addr, output, 6 bits: RAM port-A read address.
REQ-009 SHALL have port ram_a_req, output, 1 bit: high while the unloader owns RAM port A.
REQ-010 SHALL have port ram_a_q, input, DATA_W bits: RAM port-A read data, valid one cycle after the address.
REQ-011 SHALL have port out_data, output, OUT_W bits: the output chunk.
REQ-012 SHALL have port out_valid, output, 1 bit: high when out_data holds a valid chunk.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the chunk.
REQ-014 SHALL have port out_last, output, 1 bit: marks the final chunk of the final word.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, ADDR, LOAD, SHIFT.
- IDLE->ADDR on done.
- ADDR->LOAD unconditionally.
- LOAD->SHIFT unconditionally.
- SHIFT->ADDR after the last chunk of a non-final word is accepted.
- SHIFT->IDLE after the last chunk of the final word is accepted.
REQ-017 SHALL drive ram_a_addr = BASE_ADDR + word_idx in ADDR and 0 in all other states; ram_a_req SHALL be high only in ADDR and LOAD.
REQ-018 SHALL capture ram_a_q into a DATA_W shift register in LOAD (one-cycle RAM latency).
REQ-019 SHALL emit CHUNKS = ceil(DATA_W/OUT_W) chunks per word (7 at defaults), least-significant first; the final chunk SHALL be zero-extended (upper 26 bits 0 at defaults).
REQ-020 SHALL assert out_valid only in SHIFT; a transfer SHALL occur on a cycle with out_valid && out_ready.
REQ-021 SHALL ensure out_valid never depends combinationally on out_ready.
REQ-022 SHALL hold out_data and out_last stable while out_valid && !out_ready.
REQ-023 SHALL, on a transfer, advance to the next chunk on the following cycle, with no bubble within a word.
REQ-024 SHALL assert out_last only with the chunk CHUNKS-1 of word NUM_WORDS-1.
REQ-025 SHALL maintain chunk counter width clog2(CHUNKS) and word counter width clog2(NUM_WORDS); both SHALL reset to 0 on leaving IDLE and SHALL never wrap past their final value.
REQ-026 SHALL ignore done when not in IDLE; such a pulse SHALL be dropped, not queued.
REQ-027 SHALL have a minimum per-word overhead of 2 cycles (ADDR and LOAD).
REQ-028 SHALL have a minimum latency of 3 cycles from done to the first out_valid.

Reset
REQ-029 SHALL, on reset, enter IDLE and clear the counters, shift register, out_data, out_valid, out_last, busy, ram_a_req and ram_a_addr to 0.
REQ-030 SHALL, when reset occurs mid-transfer, abandon the transfer with no partial completion; out_valid SHALL be low the next cycle.

Configuration
REQ-031 SHALL, with RESULT_UNLOADER_PARITY_EN defined, add output out_parity (1 bit) equal to XOR-reduce of out_data, registered alongside out_data with identical timing and stall behaviour.
REQ-032 SHALL, without RESULT_UNLOADER_PARITY_EN, omit the port and its logic entirely.

Structure
REQ-033 SHALL place the state encoding (IDLE=0, ADDR=1, LOAD=2, SHIFT=3) and the CHUNKS derivation in a shared package, for reuse by the bench and the RAM port-A arbiter.
REQ-034 SHALL be a single module with no sub-modules; the port-A mux between the sequencer and the unloader is outside this block and keyed on ram_a_req.

Verification
REQ-035 SHALL cover: reset, one done pulse, out_ready tied 1, RAM word k = k+1 -> 42 chunks total; chunk 0 = 32'h1 and chunk 7 = 32'h2, with the rest 0 for those words; out_last only on chunk 41; busy low after the final transfer.
REQ-036 SHALL cover: out_ready toggled 1,0,0,1 repeatedly -> out_data and out_last unchanged during stalls; no chunk lost or duplicated.
REQ-037 SHALL cover: word 0 = all ones (198'h3F...F) -> chunks 0-5 = 32'hFFFFFFFF, chunk 6 = 32'h0000003F.
REQ-038 SHALL cover: second done pulse 10 cycles after the first -> ignored; still exactly 42 chunks.
REQ-039 SHALL cover: reset asserted after chunk 20 -> the next cycle has out_valid=0 and busy=0; a new done restarts from word 0, chunk 0.
REQ-040 SHALL cover, with RESULT_UNLOADER_PARITY_EN defined: out_data = 32'h00000007 -> out_parity = 1; out_data = 32'h00000003 -> out_parity = 0.
